// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The FSM side (master) consumes instruction fields and status and drives
// every enable/select; the datapath side (slave) is the mirror image.
interface multicycle_ctrl_fsm_if;
  // instruction fields and datapath status
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       zero;

  // enables
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;

  // mux selects
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;

  // status / debug
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, mem_ready, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state
  );

  modport slave (
    output opcode, funct, mem_ready, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multicycle MIPS-subset CPU. The state register is the
// only sequential element; all control outputs are decoded from it, with
// FETCH qualified by mem_ready, DECODE/EXEC/IEXEC/BRANCH looking at the
// instruction fields held stable by the IR, and BRANCH also looking at zero.
module multicycle_ctrl_fsm (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type functs
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  // mux encodings
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] DST_RT     = 2'b00;
  localparam logic [1:0] DST_RD     = 2'b01;
  localparam logic [1:0] DST_RA     = 2'b10;
  localparam logic [1:0] WD_ALUOUT  = 2'b00;
  localparam logic [1:0] WD_MDR     = 2'b01;
  localparam logic [1:0] WD_PC      = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  state_t st;
  state_t nxt;
  ctrl_t  c;

  logic is_rtype_alu;
  logic is_jr;
  logic is_mem;
  logic is_imm;
  logic is_br;

  // instruction class decode from the IR fields
  always_comb begin
    is_rtype_alu = (bus.opcode == OP_RTYPE) &&
                   ((bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                    (bus.funct == FN_SLT));
    is_jr        = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
    is_mem       = (bus.opcode == OP_LW)   || (bus.opcode == OP_SW);
    is_imm       = (bus.opcode == OP_ADDI) || (bus.opcode == OP_XORI);
    is_br        = (bus.opcode == OP_BEQ)  || (bus.opcode == OP_BNE);
  end

  // state register; reset abandons whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (reset) st <= S_FETCH;
    else       st <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (is_mem)                nxt = S_MEMADR;
        else if (is_rtype_alu)          nxt = S_EXEC;
        else if (is_jr)                 nxt = S_JR;
        else if (is_imm)                nxt = S_IEXEC;
        else if (is_br)                 nxt = S_BRANCH;
        else if (bus.opcode == OP_J)    nxt = S_JUMP;
        else if (bus.opcode == OP_JAL)  nxt = S_JAL;
        else                            nxt = S_FETCH;
      end
      S_MEMADR: begin
        if      (bus.opcode == OP_LW) nxt = S_MEMRD;
        else if (bus.opcode == OP_SW) nxt = S_MEMWR;
        else                          nxt = S_FETCH;
      end
      S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_IEXEC:  nxt = S_IWB;
      S_IWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_JAL:    nxt = S_FETCH;
      S_JR:     nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // control decode; everything defaults to 0 and is held at 0 while reset
  // is asserted so no memory or register write leaks out during reset
  always_comb begin
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b0;
        if (bus.mem_ready) begin
          c.ir_write  = 1'b1;
          c.alu_src_a = 1'b0;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALU_ADD;
          c.pc_source = PCS_ALU;
          c.pc_write  = 1'b1;
        end
      end
      S_DECODE: begin
        // speculative branch target into ALUOut
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRCB_IMMSH;
        c.alu_op    = ALU_ADD;
        c.illegal   = !(is_mem || is_rtype_alu || is_jr || is_imm || is_br ||
                        (bus.opcode == OP_J) || (bus.opcode == OP_JAL));
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RT;
        c.mem_to_reg = WD_MDR;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        case (bus.funct)
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_RWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RD;
        c.mem_to_reg = WD_ALUOUT;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (bus.opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_IWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RT;
        c.mem_to_reg = WD_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_source     = PCS_ALUOUT;
        c.pc_write_cond = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
      end
      S_JUMP: begin
        c.pc_source = PCS_JUMP;
        c.pc_write  = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        c.pc_source  = PCS_JUMP;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = WD_PC;
      end
      S_JR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_PASS;
        c.pc_source = PCS_ALU;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    if (reset) c = '0;
  end

  // drive the bundle
  always_comb begin
    bus.pc_write      = c.pc_write;
    bus.pc_write_cond = c.pc_write_cond;
    bus.iord          = c.iord;
    bus.mem_read      = c.mem_read;
    bus.mem_write     = c.mem_write;
    bus.ir_write      = c.ir_write;
    bus.reg_write     = c.reg_write;
    bus.reg_dst       = c.reg_dst;
    bus.mem_to_reg    = c.mem_to_reg;
    bus.alu_src_a     = c.alu_src_a;
    bus.alu_src_b     = c.alu_src_b;
    bus.alu_op        = c.alu_op;
    bus.pc_source     = c.pc_source;
    bus.illegal       = c.illegal;
    bus.state         = st;
  end

endmodule
